reg_cfg_master: RTL and testbench

- Register-bus initiator. Drives the `wr_en` / `rd_en` / `addr` / `write_data` / `read_data` bus that the per-layer register files (DENSE, CONV, etc.) respond to.
- Accepts write, read and poll-until-match commands over a valid/ready command channel, issues single-cycle bus accesses, and returns one result per command over a valid/ready response channel.
- Sits between the host or config sequencer and the reg_intf register-file decode.

---
 rtl/reg_cfg_pkg.sv | 31 +++
 rtl/reg_cfg_master.sv | 206 ++++++++++++++++++++
 tb/tb_reg_cfg_master.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cfg_pkg.sv
// ----------------------------------------------------------------------------
// reg_cfg_pkg
// Shared types and default widths for the register-bus initiator and the
// per-layer register files it drives.
//   REG_ADDR_W / REG_DATA_W : default register address / data widths
//   REG_TMO_W               : default poll retry-count width
//   cmd_op_t                : command opcode carried on cmd_op
//   cfg_state_t             : initiator FSM states
// ----------------------------------------------------------------------------
package reg_cfg_pkg;

  localparam int REG_ADDR_W = 14;
  localparam int REG_DATA_W = 16;
  localparam int REG_TMO_W  = 16;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSVD = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_POLL  = 3'd3,
    ST_RESP  = 3'd4
  } cfg_state_t;

endpackage : reg_cfg_pkg

// File: rtl/reg_cfg_master.sv
// ----------------------------------------------------------------------------
// reg_cfg_master
// Register-bus initiator. Takes write / read / poll-until-match commands on a
// valid/ready command channel, performs single-cycle accesses on the
// wr_en/rd_en/addr/write_data/read_data register bus, and returns one result
// per command on a valid/ready response channel.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_op                : 00 write, 01 read, 10 poll, 11 reserved
//   cmd_addr, cmd_data    : target register, write data / poll expected value
//   cmd_mask, cmd_retries : poll compare mask, extra poll reads after the first
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data, rsp_err     : result data, poll timeout / reserved-op flag
//   wr_en, rd_en          : bus strobes (registered)
//   addr, write_data      : bus address / write data (registered)
//   read_data             : bus read data, combinational from the responder
//   busy                  : FSM not idle
// ----------------------------------------------------------------------------
module reg_cfg_master
  import reg_cfg_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W,
  parameter int TMO_W  = REG_TMO_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  input  logic [TMO_W-1:0]  cmd_retries,
  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  // register bus
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  // status
  output logic              busy
);

  cfg_state_t        state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  // write_data_q doubles as the poll expected value: both come from cmd_data.
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [DATA_W-1:0] mask_q,      mask_d;
  logic [TMO_W-1:0]  cnt_q,       cnt_d;
  logic              wr_en_q,     wr_en_d;
  logic              rd_en_q,     rd_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;

  logic              cmd_fire;
  logic              poll_hit;

  // Gating with rst_n keeps cmd_ready low while reset is asserted even though
  // the state register already sits in IDLE.
  assign cmd_ready = (state_q == ST_IDLE) && rst_n;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Only bits selected by the mask take part in the poll compare.
  assign poll_hit  = ((read_data ^ write_data_q) & mask_q) == '0;

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_data_d = write_data_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d       = cmd_addr;
          write_data_d = cmd_data;
          mask_d       = cmd_mask;
          cnt_d        = cmd_retries;
          unique case (cmd_op_t'(cmd_op))
            OP_WR: begin
              state_d = ST_WRITE;
              wr_en_d = 1'b1;
            end
            OP_RD: begin
              state_d = ST_READ;
              rd_en_d = 1'b1;
            end
            OP_POLL: begin
              state_d = ST_POLL;
              rd_en_d = 1'b1;
            end
            default: begin
              // Reserved op: answer immediately, never touch the bus.
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end

      ST_WRITE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = write_data_q;
        rsp_err_d   = 1'b0;
      end

      ST_READ: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = read_data;
        rsp_err_d   = 1'b0;
      end

      ST_POLL: begin
        // Every poll cycle is a bus read; the value is kept so a timeout
        // reports the last value seen.
        rsp_data_d = read_data;
        if (poll_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          rd_en_d = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      write_data_q <= '0;
      mask_q       <= '0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      write_data_q <= write_data_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign rd_en      = rd_en_q;
  assign addr       = addr_q;
  assign write_data = write_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;

endmodule : reg_cfg_master

// File: tb/tb_reg_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_reg_cfg_master
// Directed and randomized commands against reg_cfg_master, with a register
// responder (16-entry memory or per-read scripted values) and a behavioural
// model predicting each command's strobes, latency and response.
// ----------------------------------------------------------------------------
module tb_reg_cfg_master;
  import reg_cfg_pkg::*;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [DW-1:0] cmd_mask;
  logic [TW-1:0] cmd_retries;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          busy;

  always #5 clk = ~clk;

  reg_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .cmd_retries(cmd_retries),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .write_data(write_data),
    .read_data(read_data), .busy(busy)
  );

  // Responder: memory indexed by addr[3:0], or a script of per-read values
  // restarting at every accepted command.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] script [64];
  logic          script_mode;
  logic [5:0]    rd_idx;

  assign read_data = script_mode ? script[rd_idx] : mem[addr[3:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= DW'(i * 16'h1111);
      rd_idx <= '0;
    end else begin
      if (wr_en) mem[addr[3:0]] <= write_data;
      if (cmd_valid && cmd_ready) rd_idx <= '0;
      else if (rd_en && rd_idx != 6'd63) rd_idx <= rd_idx + 6'd1;
    end
  end

  // Reference state
  logic [DW-1:0] ref_mem [16];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = DW'(i * 16'h1111);
  endtask

  // Predict a command's outcome from the register semantics.
  task automatic predict(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m,
                         input logic [TW-1:0] r,
                         output logic [DW-1:0] e_data, output logic e_err,
                         output int e_wr, output int e_rd, output int e_lat);
    logic [DW-1:0] v;
    bit hit;
    e_data = '0; e_err = 1'b0; e_wr = 0; e_rd = 0; e_lat = 0;
    case (op)
      OP_WR:   begin e_data = d; e_wr = 1; e_lat = 2; end
      OP_RD:   begin
        e_data = script_mode ? script[0] : ref_mem[a[3:0]];
        e_rd = 1; e_lat = 2;
      end
      OP_POLL: begin
        hit = 1'b0;
        for (int k = 0; k <= int'(r) && !hit; k++) begin
          v = script_mode ? script[k] : ref_mem[a[3:0]];
          e_data = v;
          e_rd = k + 1;
          if (((v ^ d) & m) == '0) hit = 1'b1;
        end
        e_err = !hit;
        e_lat = e_rd + 1;
      end
      default: begin e_data = '0; e_err = 1'b1; e_lat = 1; end
    endcase
  endtask

  // Issue one command, observe it to completion and compare with the model.
  // hold > 0 keeps rsp_ready low for that many cycles while a follow-up
  // write (ja/jd) waits on cmd_valid; that write must go out right after.
  task automatic run_cmd(input string tag, input logic [1:0] op,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m, input logic [TW-1:0] r,
                         input int hold, input logic [AW-1:0] ja,
                         input logic [DW-1:0] jd);
    logic [DW-1:0] e_data;
    logic e_err;
    int e_wr, e_rd, e_lat;
    int nwr, nrd, lat, overlap, bad_bus, hold_bad;
    bit got;
    predict(op, a, d, m, r, e_data, e_err, e_wr, e_rd, e_lat);
    nwr = 0; nrd = 0; lat = 0; overlap = 0; bad_bus = 0; hold_bad = 0; got = 0;

    @(negedge clk);
    check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    cmd_mask = m; cmd_retries = r; rsp_ready = 1'b0;
    for (int c = 1; c <= 80 && !got; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (wr_en && rd_en) overlap++;
      if (wr_en) begin
        nwr++;
        if (addr !== a || write_data !== d) bad_bus++;
      end
      if (rd_en) begin
        nrd++;
        if (addr !== a) bad_bus++;
      end
      if (rsp_valid) begin got = 1; lat = c; end
    end
    if (!got) begin
      check_eq({tag, "_rsp_timeout"}, 0, 1);
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      rsp_ready = 1'b0;
      return;
    end
    check_eq({tag, "_latency"}, lat, e_lat);
    check_eq({tag, "_wr_cnt"}, nwr, e_wr);
    check_eq({tag, "_rd_cnt"}, nrd, e_rd);
    check_eq({tag, "_overlap"}, overlap, 0);
    check_eq({tag, "_bus_addr_data"}, bad_bus, 0);
    check_eq({tag, "_rsp_data"}, rsp_data, e_data);
    check_eq({tag, "_rsp_err"}, rsp_err, e_err);
    check_eq({tag, "_busy_resp"}, {busy, cmd_ready}, 2'b10);
    if (op == OP_WR) ref_mem[a[3:0]] = d;

    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_op = OP_WR; cmd_addr = ja; cmd_data = jd;
      repeat (hold) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== e_data || rsp_err !== e_err ||
            cmd_ready !== 1'b0 || wr_en || rd_en) hold_bad++;
      end
      check_eq({tag, "_hold_stable"}, hold_bad, 0);
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_released"}, {rsp_valid, cmd_ready, busy}, 3'b010);

    if (hold > 0) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq({tag, "_next_accept"}, {wr_en, addr, write_data}, {1'b1, ja, jd});
      ref_mem[ja[3:0]] = jd;
      @(negedge clk);
      check_eq({tag, "_next_rsp"}, {rsp_valid, rsp_data}, {1'b1, jd});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  int pulses, bad;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0;
    cmd_data = '0; cmd_mask = '0; cmd_retries = '0; rsp_ready = 1'b0;
    script_mode = 1'b0;
    for (int i = 0; i < 64; i++) script[i] = '0;
    ref_reset();

    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {cmd_ready, rsp_valid, rsp_err, rsp_data, wr_en, rd_en, addr, write_data, busy},
             '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", cmd_ready, 1);

    // Directed cases
    run_cmd("wr401", OP_WR, 14'h401, 16'h0005, 16'h0, 16'd0, 0, '0, '0);

    script_mode = 1'b1; script[0] = 16'h0001;
    run_cmd("rd40c", OP_RD, 14'h40c, 16'h0, 16'h0, 16'd0, 0, '0, '0);

    script[0] = 16'h0000; script[1] = 16'h0000; script[2] = 16'hAB10;
    run_cmd("poll405", OP_POLL, 14'h405, 16'h0010, 16'h00FF, 16'd7, 0, '0, '0);

    for (int i = 0; i < 64; i++) script[i] = DW'(16'h0100 + i);
    run_cmd("poll_tmo", OP_POLL, 14'h022, 16'h0000, 16'hFFFF, 16'd4, 0, '0, '0);

    run_cmd("poll_mask0", OP_POLL, 14'h023, 16'h5A5A, 16'h0000, 16'd9, 0, '0, '0);
    run_cmd("poll_r0", OP_POLL, 14'h024, 16'h7777, 16'hFFFF, 16'd0, 0, '0, '0);

    script_mode = 1'b0;
    run_cmd("rd_hold", OP_RD, 14'h401, 16'h0, 16'h0, 16'd0, 10, 14'h00A, 16'hC0DE);
    run_cmd("rsvd", OP_RSVD, 14'h3FF, 16'hFFFF, 16'hFFFF, 16'd3, 0, '0, '0);
    run_cmd("rd_back", OP_RD, 14'h00A, 16'h0, 16'h0, 16'd0, 0, '0, '0);

    // Back-to-back writes with rsp_ready tied high: one write every 3 cycles.
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = OP_WR;
    cmd_addr = 14'h003; cmd_data = 16'hBEEF;
    pulses = 0;
    repeat (9) begin
      @(negedge clk);
      if (wr_en) pulses++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    ref_mem[3] = 16'hBEEF;
    check_eq("b2b_wr_pulses", pulses, 3);
    @(negedge clk);

    // Reset in the middle of a long poll
    script_mode = 1'b1;
    for (int i = 0; i < 64; i++) script[i] = 16'h0000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_POLL; cmd_addr = 14'h011; cmd_data = 16'h1234;
    cmd_mask = 16'hFFFF; cmd_retries = 16'd20;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("mid_poll_rd_en", rd_en, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_poll", {rd_en, rsp_valid, busy, cmd_ready}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    ref_reset();
    @(negedge clk);
    check_eq("ready_after_rst2", cmd_ready, 1);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || rd_en || wr_en || busy) bad++;
    end
    check_eq("no_rsp_after_reset", bad, 0);

    // Randomized commands
    for (int n = 0; n < 60; n++) begin
      logic [1:0]    op;
      logic [AW-1:0] a;
      logic [DW-1:0] d, m;
      logic [TW-1:0] r;
      int            h;
      op = 2'($urandom_range(0, 3));
      a  = AW'($urandom);
      r  = TW'($urandom_range(0, 6));
      h  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      script_mode = (op == OP_RD || op == OP_POLL) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (op == OP_POLL && script_mode) begin
        d = DW'($urandom_range(0, 3));
        m = DW'($urandom_range(0, 3));
        for (int i = 0; i < 64; i++) script[i] = DW'({$urandom_range(0, 3)} | ($urandom & 32'hFFF0));
      end else begin
        d = DW'($urandom);
        m = ($urandom_range(0, 3) == 0) ? 16'h0000 : DW'($urandom);
        for (int i = 0; i < 64; i++) script[i] = DW'($urandom);
      end
      run_cmd("rand", op, a, d, m, r, h, AW'($urandom), DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_reg_cfg_master
